fetch_unit: RTL and testbench

Instruction fetch stage placed between the PC/branch logic and the decode/execute datapath. It issues word fetches to a variable-latency instruction memory over a req/ack handshake. Fetched words are buffered in a small prefetch queue and presented downstream with valid/ready. A redirect input, driven by the taken-branch target, flushes the queue and restarts fetch at the new PC, discarding any stale in-flight response.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared widths, encodings and FSM states of fetch stage   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : imem req/ack bus, instruction stream and redirect    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : prefetch queue of {pc, inst} with flush and count       |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [XLEN-1:0]        push_pc,
  input  logic [XLEN-1:0]        push_inst,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [XLEN-1:0]        head_pc,
  output logic [XLEN-1:0]        head_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE    = (AW+1)'(1);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic            empty;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  assign head_pc   = empty ? '0       : pc_mem[rd_ptr];
  assign head_inst = empty ? NOP_INST : inst_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : imem request FSM feeding a prefetch queue, with redirect|
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e    state, state_next;
  logic            req, req_next;
  logic [XLEN-1:0] addr, addr_next;
  logic [XLEN-1:0] fetch_pc, pc_next;
  logic [CW-1:0]   count, count_after;
  logic            complete, push, pop, head_valid, space;
  logic [XLEN-1:0] target, pc_plus, resume_pc;
  logic [XLEN-1:0] head_pc, head_inst;

  assign complete   = req & bus.imem_ack;
  assign target     = word_align(bus.redirect_pc);
  assign head_valid = (count != '0);
  assign push       = complete & (state == WAIT) & ~bus.redirect;
  assign pop        = head_valid & bus.inst_ready & ~bus.redirect;
  assign pc_plus    = fetch_pc + XLEN'(INST_BYTES);
  assign resume_pc  = bus.redirect ? target : fetch_pc;

  // Occupancy as it will be after this edge; issuing needs a free slot then.
  always_comb begin
    count_after = count;
    if (bus.redirect) begin
      count_after = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_after = count + ONE;
        2'b01:   count_after = count - ONE;
        default: count_after = count;
      endcase
    end
  end

  assign space = (count_after < DEPTH_C);

  always_comb begin
    state_next = state;
    req_next   = req;
    addr_next  = addr;
    pc_next    = fetch_pc;
    unique case (state)
      IDLE: begin
        if (bus.redirect) begin
          pc_next    = target;
          req_next   = 1'b1;
          addr_next  = target;
          state_next = WAIT;
        end else if (space) begin
          req_next   = 1'b1;
          addr_next  = fetch_pc;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          pc_next = target;
          if (complete) begin
            addr_next = target;
          end else begin
            state_next = DISCARD;
          end
        end else if (complete) begin
          pc_next = pc_plus;
          if (space) begin
            addr_next = pc_plus;
          end else begin
            req_next   = 1'b0;
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bus.redirect) pc_next = target;
        if (complete) begin
          if (space) begin
            addr_next  = resume_pc;
            state_next = WAIT;
          end else begin
            req_next   = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      req      <= req_next;
      addr     <= addr_next;
      fetch_pc <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_pc   (addr),
    .push_inst (bus.imem_rdata),
    .pop       (pop),
    .count     (count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_inst;
  assign bus.inst_pc    = head_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Directed bench for fetch_unit: a memory model answers requests after a
// programmable number of wait cycles with data 0xC0DE_xxxx (xxxx = addr[15:0]).
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_delay = 0;
  bit   hold = 1'b0;
  int   wcnt = 0;
  int   comp_cnt = 0;
  logic [31:0] last_addr = '0;
  int   base;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset || !bus.imem_req || bus.imem_ack) wcnt = 0;
    else wcnt = wcnt + 1;
    if (reset && bus.imem_req && bus.imem_ack) begin
      comp_cnt  = comp_cnt + 1;
      last_addr = bus.imem_addr;
    end
  end

  always @(negedge clock) begin
    #1;
    bus.imem_ack   = bus.imem_req && !hold && (wcnt >= ack_delay);
    bus.imem_rdata = 32'hC0DE_0000 | {16'h0, bus.imem_addr[15:0]};
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Returns on the negedge at which reset is released.
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; bus.redirect = 1'b0; hold = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.inst_ready = 1'b1; ack_delay = 0;
    @(negedge clock); reset = 1'b0; cycles(1);
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 00000000", bus.imem_addr); end
    vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", bus.inst_valid); end
  endtask

  task automatic test_stream();
    ack_delay = 0; bus.inst_ready = 1'b1;
    apply_reset();
    cycles(1);
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL stream_e1: req %b addr %h expected 1 00000000", bus.imem_req, bus.imem_addr); end
    vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL stream_e1_valid: got %b expected 0", bus.inst_valid); end
    cycles(1);
    vectors++; if (bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL stream_e2_addr: got %h expected 00000004", bus.imem_addr); end
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'hC0DE_0000) begin miscompares++; $display("FAIL stream_e2_inst: valid %b pc %h inst %h expected 1 00000000 c0de0000", bus.inst_valid, bus.inst_pc, bus.inst); end
    cycles(1);
    vectors++; if (bus.imem_addr !== 32'h8 || bus.inst_pc !== 32'h4) begin miscompares++; $display("FAIL stream_e3: addr %h pc %h expected 00000008 00000004", bus.imem_addr, bus.inst_pc); end
    cycles(1);
    vectors++; if (bus.inst_pc !== 32'h8 || bus.inst !== 32'hC0DE_0008) begin miscompares++; $display("FAIL stream_e4: pc %h inst %h expected 00000008 c0de0008", bus.inst_pc, bus.inst); end
  endtask

  task automatic test_full();
    ack_delay = 0; bus.inst_ready = 1'b0;
    apply_reset();
    base = comp_cnt;
    cycles(10);
    vectors++; if (comp_cnt - base !== 4) begin miscompares++; $display("FAIL full_count: got %0d expected 4", comp_cnt - base); end
    vectors++; if (last_addr !== 32'hC) begin miscompares++; $display("FAIL full_last: got %h expected 0000000c", last_addr); end
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL full_req: got %b expected 0", bus.imem_req); end
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'hC0DE_0000) begin miscompares++; $display("FAIL full_head: valid %b pc %h inst %h expected 1 00000000 c0de0000", bus.inst_valid, bus.inst_pc, bus.inst); end
    bus.inst_ready = 1'b1;
    cycles(1);
    vectors++; if (bus.inst_pc !== 32'h4 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin miscompares++; $display("FAIL full_drain: pc %h req %b addr %h expected 00000004 1 00000010", bus.inst_pc, bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_wait_states();
    ack_delay = 3; bus.inst_ready = 1'b1;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      cycles(1);
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL wait_hold%0d: req %b addr %h valid %b expected 1 00000000 0", i, bus.imem_req, bus.imem_addr, bus.inst_valid); end
    end
    cycles(1);
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'hC0DE_0000 || bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL wait_first: valid %b pc %h inst %h addr %h expected 1 00000000 c0de0000 00000004", bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr); end
    cycles(1);
    vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL wait_gap: valid %b addr %h expected 0 00000004", bus.inst_valid, bus.imem_addr); end
    cycles(3);
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4 || bus.inst !== 32'hC0DE_0004) begin miscompares++; $display("FAIL wait_second: valid %b pc %h inst %h expected 1 00000004 c0de0004", bus.inst_valid, bus.inst_pc, bus.inst); end
  endtask

  task automatic test_redirect_discard();
    ack_delay = 0; bus.inst_ready = 1'b1;
    apply_reset();
    cycles(3);
    hold = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    cycles(1);
    bus.redirect = 1'b0;
    vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin miscompares++; $display("FAIL disc_squash: valid %b req %b addr %h expected 0 1 00000008", bus.inst_valid, bus.imem_req, bus.imem_addr); end
    cycles(1);
    hold = 1'b0;
    cycles(1);
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL disc_reissue: req %b addr %h valid %b expected 1 00000100 0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
    cycles(1);
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== 32'hC0DE_0100) begin miscompares++; $display("FAIL disc_first: valid %b pc %h inst %h expected 1 00000100 c0de0100", bus.inst_valid, bus.inst_pc, bus.inst); end
  endtask

  task automatic test_redirect_complete();
    ack_delay = 0; bus.inst_ready = 1'b1;
    apply_reset();
    cycles(3);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h203;
    cycles(1);
    bus.redirect = 1'b0;
    vectors++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin miscompares++; $display("FAIL rdc_flush: valid %b req %b addr %h expected 0 1 00000200", bus.inst_valid, bus.imem_req, bus.imem_addr); end
    cycles(1);
    vectors++; if (bus.inst_pc !== 32'h200 || bus.inst !== 32'hC0DE_0200 || bus.imem_addr !== 32'h204) begin miscompares++; $display("FAIL rdc_first: pc %h inst %h addr %h expected 00000200 c0de0200 00000204", bus.inst_pc, bus.inst, bus.imem_addr); end
  endtask

  task automatic test_pc_wrap();
    ack_delay = 0; bus.inst_ready = 1'b1;
    apply_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    cycles(1);
    bus.redirect = 1'b0;
    vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_issue: got %h expected fffffffc", bus.imem_addr); end
    cycles(1);
    vectors++; if (bus.imem_addr !== 32'h0 || bus.inst_pc !== 32'hFFFF_FFFC || bus.inst !== 32'hC0DE_FFFC) begin miscompares++; $display("FAIL wrap_next: addr %h pc %h inst %h expected 00000000 fffffffc c0defffc", bus.imem_addr, bus.inst_pc, bus.inst); end
  endtask

  task automatic test_reset_mid();
    ack_delay = 0; bus.inst_ready = 1'b1;
    apply_reset();
    cycles(3);
    #2 reset = 1'b0;
    #1;
    vectors++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_rst: req %b valid %b addr %h expected 0 0 00000000", bus.imem_req, bus.inst_valid, bus.imem_addr); end
    cycles(2);
    reset = 1'b1;
    cycles(1);
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart: req %b addr %h expected 1 00000000", bus.imem_req, bus.imem_addr); end
    cycles(1);
    vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL mid_first: valid %b pc %h expected 1 00000000", bus.inst_valid, bus.inst_pc); end
  endtask

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.imem_ack = 1'b0;
    bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_wait_states();
    test_redirect_discard();
    test_redirect_complete();
    test_pc_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
